// File: rtl/lsu.sv
// Load/store unit: takes one access from execute, runs it over the
// memory valid/ready channel, and returns aligned/extended load data.
// One access in flight; misaligned or illegal accesses fault without
// touching memory.
module lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wen,
   input  logic [2:0]        in_funct3,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [31:0]       in_wdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   output logic [3:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_rdata,
   output logic              out_fault
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t              state_q, state_d;
   logic                wen_q, wen_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [1:0]          off_q, off_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [31:0]         req_wdata_q, req_wdata_d;
   logic [3:0]          req_wmask_q, req_wmask_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                fault_q, fault_d;
   logic                accept;

   // Illegal size codes, unsigned stores, and unaligned halves/words fault.
   function automatic logic is_fault(input logic wen, input logic [2:0] f3,
                                     input logic [1:0] lo);
      logic bad;
      case (f3)
         3'b000:  bad = 1'b0;
         3'b100:  bad = wen;
         3'b001:  bad = lo[0];
         3'b101:  bad = wen | lo[0];
         3'b010:  bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte enables for a store of the given size at the given lane.
   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Shift the addressed lane down to bit 0, then sign/zero extend.
   function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic [31:0] lane;
      logic [31:0] r;
      lane = word >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{lane[7]}}, lane[7:0]};
         3'b100:  r = {24'd0, lane[7:0]};
         3'b001:  r = {{16{lane[15]}}, lane[15:0]};
         3'b101:  r = {16'd0, lane[15:0]};
         default: r = lane;
      endcase
      return r;
   endfunction

   assign accept = in_valid && (state_q == IDLE);

   // State and datapath registers; reset clears everything visible on the ports.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wen_q       <= 1'b0;
         funct3_q    <= 3'd0;
         off_q       <= 2'd0;
         req_addr_q  <= '0;
         req_wdata_q <= 32'd0;
         req_wmask_q <= 4'd0;
         rdata_q     <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
         rdata_q     <= rdata_d;
         fault_q     <= fault_d;
      end
   end

   // Next-state: faults skip memory entirely and go straight to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = is_fault(in_wen, in_funct3, in_addr[1:0]) ? DONE : REQ;
         REQ:  if (mem_req_ready) state_d = RESP;
         RESP: if (mem_resp_valid) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch and format the access on accept; capture load data on response.
   always_comb begin
      wen_d       = wen_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;
      rdata_d     = rdata_q;
      fault_d     = fault_q;
      if (accept) begin
         wen_d       = in_wen;
         funct3_d    = in_funct3;
         off_d       = in_addr[1:0];
         req_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
         req_wdata_d = in_wen ? (in_wdata << {in_addr[1:0], 3'b000}) : 32'd0;
         req_wmask_d = in_wen ? store_mask(in_funct3, in_addr[1:0]) : 4'd0;
         rdata_d     = 32'd0;
         fault_d     = is_fault(in_wen, in_funct3, in_addr[1:0]);
      end else if (state_q == RESP && mem_resp_valid && !wen_q) begin
         rdata_d = load_format(funct3_q, off_q, mem_resp_rdata);
      end
   end

   // Port outputs; in_ready is held low while reset is asserted.
   always_comb begin
      in_ready      = rst_n && (state_q == IDLE);
      mem_req_valid = (state_q == REQ);
      mem_req_wen   = wen_q;
      mem_req_addr  = req_addr_q;
      mem_req_wdata = req_wdata_q;
      mem_req_wmask = req_wmask_q;
      out_valid     = (state_q == DONE);
      out_rdata     = rdata_q;
      out_fault     = fault_q;
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: transaction-level reference model plus a per-cycle
// compare process, directed cases with literal expectations, and a
// randomized run with random back-pressure and stray responses.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_wen;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic        out_valid, out_ready, out_fault;
   logic [31:0] out_rdata;

   lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata(out_rdata), .out_fault(out_fault)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected phase of the current access, advanced by the driver.
   bit          chk_en = 0;
   bit          exp_idle = 0, exp_req = 0, exp_out = 0;
   bit          cur_wen, cur_fault;
   logic [31:0] cur_addr, cur_req_wdata, cur_rdata;
   logic [3:0]  cur_mask;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_mask;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---- reference model ----
   function automatic bit m_fault(bit wen, int f3, int lo);
      int size;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
      if (wen && f3 >= 4) return 1;
      size = 1 << (f3 % 4);
      return (lo % size) != 0;
   endfunction

   function automatic logic [31:0] m_load(int f3, int off, logic [31:0] rd);
      int b[4];
      int v;
      for (int i = 0; i < 4; i++) b[i] = int'(rd[8*i +: 8]);
      case (f3)
         0: begin v = b[off]; if (v >= 128) v = v - 256; end
         4: v = b[off];
         1: begin v = b[off] + 256 * b[off+1]; if (v >= 32768) v = v - 65536; end
         5: v = b[off] + 256 * b[off+1];
         default: return rd;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [3:0] m_mask(bit wen, int f3, int off);
      int m = 0;
      if (!wen) return 4'd0;
      for (int i = off; i < off + (1 << (f3 % 4)); i++) m = m + (1 << i);
      return 4'(m);
   endfunction

   // Per-cycle compare against the expected phase and fields.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, exp_idle);
         check("mem_req_valid", mem_req_valid, exp_req);
         check("out_valid", out_valid, exp_out);
         if (exp_req) begin
            check("mem_req_wen", mem_req_wen, cur_wen);
            check("mem_req_addr", mem_req_addr, cur_addr & 32'hFFFF_FFFC);
            check("mem_req_wmask", mem_req_wmask, cur_mask);
            if (cur_wen) check("mem_req_wdata", mem_req_wdata, cur_req_wdata);
         end
         if (exp_out) begin
            check("out_rdata", out_rdata, cur_rdata);
            check("out_fault", out_fault, cur_fault);
         end
      end
   end

   task automatic check_reset_outs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_mem_req_valid"}, mem_req_valid, 0);
      check({tag, "_mem_req_wen"}, mem_req_wen, 0);
      check({tag, "_mem_req_addr"}, mem_req_addr, 0);
      check({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
      check({tag, "_mem_req_wmask"}, mem_req_wmask, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_rdata"}, out_rdata, 0);
      check({tag, "_out_fault"}, out_fault, 0);
   endtask

   task automatic set_expect(input bit wen, input int f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd);
      int off = int'(addr[1:0]);
      cur_wen       = wen;
      cur_addr      = addr;
      cur_fault     = m_fault(wen, f3, off);
      cur_mask      = m_mask(wen, f3, off);
      cur_req_wdata = wd << (8 * off);
      cur_rdata     = (cur_fault || wen) ? 32'd0 : m_load(f3, off, rd);
   endtask

   // Runs one access from an idle negedge back to an idle negedge.
   task automatic do_access(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int req_dly, input int resp_dly, input int out_dly,
                            output logic [31:0] got_rdata, output logic got_fault);
      set_expect(wen, int'(f3), addr, wd, rd);
      in_valid = 1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wd;
      @(posedge clk); #1;
      in_valid = 0; in_wdata = $urandom; in_addr = $urandom;
      exp_idle = 0;
      if (cur_fault) exp_out = 1; else exp_req = 1;
      @(negedge clk);
      if (!cur_fault) begin
         seen_addr = mem_req_addr; seen_wdata = mem_req_wdata; seen_mask = mem_req_wmask;
         for (int i = 0; i < req_dly; i++) begin
            mem_req_ready = 0; @(posedge clk); @(negedge clk);
         end
         mem_req_ready = 1;
         @(posedge clk); #1;
         mem_req_ready = 0; exp_req = 0;
         @(negedge clk);
         for (int i = 0; i < resp_dly; i++) begin
            @(posedge clk); @(negedge clk);
         end
         mem_resp_valid = 1; mem_resp_rdata = rd;
         @(posedge clk); #1;
         mem_resp_valid = 0; mem_resp_rdata = $urandom; exp_out = 1;
         @(negedge clk);
      end
      got_rdata = out_rdata; got_fault = out_fault;
      for (int i = 0; i < out_dly; i++) begin
         out_ready = 0;
         mem_resp_valid = 1'($urandom % 2); mem_resp_rdata = $urandom;
         @(posedge clk); @(negedge clk);
      end
      mem_resp_valid = 0;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0; exp_out = 0; exp_idle = 1;
      @(negedge clk);
   endtask

   logic [31:0] r;
   logic        f;

   initial begin
      rst_n = 0; in_valid = 0; in_wen = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 0;
      repeat (3) @(posedge clk);
      #1 check_reset_outs("rst");
      @(negedge clk); rst_n = 1; exp_idle = 1;
      @(posedge clk); #1 chk_en = 1;
      @(negedge clk);

      // lw, ready memory
      do_access(0, 3'b010, 32'h8000_0010, 0, 32'hDEAD_BEEF, 0, 0, 0, r, f);
      check("lw_rdata", r, 32'hDEAD_BEEF);
      check("lw_fault", f, 0);
      check("lw_addr", seen_addr, 32'h8000_0010);
      check("lw_mask", seen_mask, 4'b0000);

      // byte/half loads
      do_access(0, 3'b000, 32'h8000_0003, 0, 32'h80FF_1234, 0, 0, 0, r, f);
      check("lb_rdata", r, 32'hFFFF_FF80);
      do_access(0, 3'b100, 32'h8000_0003, 0, 32'h80FF_1234, 0, 0, 0, r, f);
      check("lbu_rdata", r, 32'h0000_0080);
      do_access(0, 3'b001, 32'h8000_0002, 0, 32'h80FF_1234, 0, 0, 0, r, f);
      check("lh_rdata", r, 32'hFFFF_80FF);
      do_access(0, 3'b101, 32'h8000_0002, 0, 32'h80FF_1234, 0, 0, 0, r, f);
      check("lhu_rdata", r, 32'h0000_80FF);

      // sh
      do_access(1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h5555_5555, 0, 0, 0, r, f);
      check("sh_wdata", seen_wdata, 32'hABCD_0000);
      check("sh_mask", seen_mask, 4'b1100);
      check("sh_addr", seen_addr, 32'h8000_0000);
      check("sh_rdata", r, 0);

      // faults
      do_access(0, 3'b010, 32'h8000_0006, 0, 0, 0, 0, 0, r, f);
      check("lw_mis_fault", f, 1);
      check("lw_mis_rdata", r, 0);
      do_access(1, 3'b100, 32'h8000_0000, 32'h11, 0, 0, 0, 0, r, f);
      check("sbu_fault", f, 1);

      // back-pressure on all channels
      do_access(0, 3'b010, 32'h8000_0040, 0, 32'h0BAD_F00D, 3, 2, 2, r, f);
      check("bp_rdata", r, 32'h0BAD_F00D);

      // reset while waiting for a response
      set_expect(0, 2, 32'h8000_0020, 0, 32'h1234_5678);
      in_valid = 1; in_wen = 0; in_funct3 = 3'b010; in_addr = 32'h8000_0020;
      @(posedge clk); #1 in_valid = 0; exp_idle = 0; exp_req = 1; mem_req_ready = 1;
      @(negedge clk);
      @(posedge clk); #1 exp_req = 0; mem_req_ready = 0;
      @(negedge clk);
      chk_en = 0; rst_n = 0;
      #1 check("rst_mid_in_ready", in_ready, 0);
      @(posedge clk); #1 check_reset_outs("rst_mid");
      @(negedge clk); rst_n = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
      #1 check("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1 mem_resp_valid = 0;
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_req_valid", mem_req_valid, 0);
      check("post_rst_in_ready2", in_ready, 1);
      check("post_rst_rdata", out_rdata, 0);
      exp_idle = 1; exp_req = 0; exp_out = 0;
      @(negedge clk); chk_en = 1;
      do_access(0, 3'b010, 32'h8000_0024, 0, 32'hCAFE_0001, 0, 0, 0, r, f);
      check("after_rst_lw", r, 32'hCAFE_0001);

      // randomized accesses
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a;
         a = 32'h8000_0000 | ($urandom & 32'h0000_0FFC) | ($urandom % 4);
         do_access(1'($urandom % 2), 3'($urandom % 8), a, $urandom, $urandom,
                   int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), r, f);
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit that sits directly upstream of the data memory in the NPC core.
- Accepts one load or store from the execute stage and performs the access over a valid/ready request/response channel.
- Formats write data and byte mask.
- Aligns and extends read data before handing the result to writeback.
- Detects misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width of the in_addr and mem_req_addr ports.

Ports:
- clk  input  1  core clock; all state changes on posedge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  execute stage presents an access.
- in_ready  output  1  lsu can accept an access.
- in_wen  input  1  1 = store, 0 = load.
- in_funct3  input  3  RISC-V size/sign code.
- in_addr  input  ADDR_W  byte address.
- in_wdata  input  32  store data, right-aligned.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_wen  output  1  write request.
- mem_req_addr  output  ADDR_W  word-aligned address ({in_addr[ADDR_W-1:2], 2'b00}).
- mem_req_wdata  output  32  lane-shifted store data.
- mem_req_wmask  output  4  byte enables; 0000 for loads.
- mem_resp_valid  input  1  memory response; one pulse per accepted request.
- mem_resp_rdata  input  32  full read word.
- out_valid  output  1  result available to writeback.
- out_ready  input  1  writeback consumes the result.
- out_rdata  output  32  extended load data; 0 for stores and faults.
- out_fault  output  1  misaligned or illegal access.

Behaviour:
- Reset (rst_n low at posedge): state=IDLE. Outputs in_ready=0 during reset, then 1 in IDLE. mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, out_valid=0, out_rdata=0, out_fault=0.
- Reset mid-operation drops the in-flight access. Any later mem_resp_valid while in IDLE is ignored.
- FSM states: IDLE, REQ, RESP, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid & in_ready, latch wen, funct3, addr, wdata.
  - Fault condition: funct3 in {011, 110, 111}; or store with funct3 in {100, 101}; or half access with addr[0]=1; or word access with addr[1:0]!=0.
  - On fault: go to DONE with out_fault=1 and out_rdata=0. No memory request is issued.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1; all mem_req_* fields are stable until the handshake. On mem_req_ready, go to RESP.
- RESP: mem_req_valid=0. Wait for mem_resp_valid, which is sampled only in this state.
  - Load: capture the formatted data.
  - Store: ignore rdata.
  - Go to DONE.
- DONE: out_valid=1; out_rdata and out_fault are held stable. On out_ready, go to IDLE.
- Latency with ready memory (mem_req_ready=1 and mem_resp_valid the cycle after the handshake): accept at edge 0, request during cycle 1, response during cycle 2, out_valid during cycle 3. A faulted access shows out_valid during cycle 1.
- Store formatting:
  - Data: wdata << 8*addr[1:0].
  - Mask: sb = 0001<<addr[1:0]; sh = 0011<<addr[1:0]; sw = 1111.
- Load formatting: byte lane = rdata >> 8*addr[1:0].
  - 000 lb: sign-extend bit 7.
  - 100 lbu: zero-extend.
  - 001 lh: sign-extend bit 15.
  - 101 lhu: zero-extend.
  - 010 lw: full word.
- No new access is accepted until DONE completes; there is no pipelining and only one outstanding access.

Test Plan:
- Reset, then lw addr=0x80000010; memory returns 0xDEADBEEF with ready=1 -> mem_req_addr=0x80000010, wmask=0000; out_valid in cycle 3, out_rdata=0xDEADBEEF, out_fault=0.
- lb addr=0x80000003 with rdata=0x80FF1234 -> out_rdata=0xFFFFFF80. Same access as lbu -> 0x00000080. lh addr=...2 -> 0xFFFF80FF. lhu -> 0x000080FF.
- sh addr=0x80000002, wdata=0x0000ABCD -> mem_req_wen=1, wdata=0xABCD0000, wmask=1100, addr=0x80000000; out_rdata=0 on completion.
- lw addr=0x80000006 -> out_fault=1 one cycle after accept, mem_req_valid never asserted. sb with funct3=100 -> out_fault=1.
- Back-pressure: mem_req_ready low 3 cycles, then high. Response 2 cycles later. out_ready low 2 cycles. -> mem_req_* stable while waiting; out_valid/out_rdata held stable; in_ready=0 throughout; in_ready returns to 1 the cycle after the out handshake.
- Assert rst_n=0 for one cycle while in RESP, then inject mem_resp_valid -> all outputs at reset values, response ignored. A new lw then completes normally.
